// File: rtl/xadc_drp_sampler_pkg.sv
// xadc_drp_sampler_pkg: DRP register map, sampler FSM states and packet header constants
package xadc_drp_package;
   localparam logic [6:0] XADC_DRP_ADDR_VOLTAGE = 7'h03;
   localparam logic [6:0] XADC_DRP_ADDR_CURRENT = 7'h13;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      V_WAIT  = 2'd1,
      C_WAIT  = 2'd2,
      PUBLISH = 2'd3
   } xadc_drp_sampler_state_t;
endpackage

package xadc_packet_package;
   localparam logic [3:0] XADC_PACKET_HEADER_LOW_SPEED_SAMPLE = 4'h1;
endpackage

// File: rtl/xadc_drp_sampler_read_port.sv
// xadc_drp_read_port: one DRP read per start pulse, with drdy timeout
module xadc_drp_read_port #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  addr,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic        drp_den,
   output logic [6:0]  drp_daddr,
   output logic        done,
   output logic [11:0] data,
   output logic        timeout
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
   logic          busy_q, busy_d, den_q, den_d;
   logic [6:0]    addr_q, addr_d;
   logic [TW-1:0] timer_q, timer_d;
   assign done      = busy_q & drp_drdy;
   assign timeout   = busy_q & ~drp_drdy & (timer_q == LAST);
   assign data      = drp_do[15:4];
   assign drp_den   = den_q;
   assign drp_daddr = addr_q;
   // den is a one-cycle pulse after start; busy covers the den cycle so the timer spans the whole read
   always_comb begin
      den_d   = start;
      addr_d  = start ? addr : addr_q;
      busy_d  = start | (busy_q & ~done & ~timeout);
      timer_d = start ? '0 : (busy_q ? timer_q + 1'b1 : timer_q);
   end
   // read state registers; reset drops any read in flight so a late drdy finds busy low
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         den_q   <= 1'b0;
         addr_q  <= '0;
         timer_q <= '0;
      end else begin
         busy_q  <= busy_d;
         den_q   <= den_d;
         addr_q  <= addr_d;
         timer_q <= timer_d;
      end
   end
endmodule

// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: on eos reads voltage then current over DRP and publishes them as an aligned stream pair
module xadc_drp_sampler
   import xadc_drp_package::*, xadc_packet_package::*;
#(
   parameter logic [6:0] VOLTAGE_DRP_ADDR = XADC_DRP_ADDR_VOLTAGE,
   parameter logic [6:0] CURRENT_DRP_ADDR = XADC_DRP_ADDR_CURRENT,
   parameter logic [3:0] SAMPLE_HEADER    = XADC_PACKET_HEADER_LOW_SPEED_SAMPLE,
   parameter int         DRP_TIMEOUT      = 64,
   parameter int         DROP_COUNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        eos,
   output logic                        drp_den,
   output logic                        drp_dwe,
   output logic [6:0]                  drp_daddr,
   output logic [15:0]                 drp_di,
   input  logic [15:0]                 drp_do,
   input  logic                        drp_drdy,
   output logic [15:0]                 voltage_tdata,
   output logic                        voltage_tvalid,
   input  logic                        voltage_tready,
   output logic [15:0]                 current_tdata,
   output logic                        current_tvalid,
   input  logic                        current_tready,
   output logic [DROP_COUNT_WIDTH-1:0] drop_count,
   output logic                        drp_timeout_err
);
   xadc_drp_sampler_state_t     state_q, state_d;
   logic                        pending_q, pending_d;
   logic [11:0]                 v_hold_q, v_hold_d, c_hold_q, c_hold_d;
   logic [15:0]                 v_data_q, v_data_d, c_data_q, c_data_d;
   logic                        v_valid_q, v_valid_d, c_valid_q, c_valid_d;
   logic [DROP_COUNT_WIDTH-1:0] drop_q, drop_d;
   logic                        err_q, err_d;
   logic                        start, rd_done, rd_timeout, load, drop;
   logic [6:0]                  rd_addr;
   logic [11:0]                 rd_data;
   xadc_drp_read_port #(.TIMEOUT(DRP_TIMEOUT)) u_read (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .addr      (rd_addr),
      .drp_do    (drp_do),
      .drp_drdy  (drp_drdy),
      .drp_den   (drp_den),
      .drp_daddr (drp_daddr),
      .done      (rd_done),
      .data      (rd_data),
      .timeout   (rd_timeout)
   );
   assign drp_dwe         = 1'b0;
   assign drp_di          = '0;
   assign voltage_tdata   = v_data_q;
   assign voltage_tvalid  = v_valid_q;
   assign current_tdata   = c_data_q;
   assign current_tvalid  = c_valid_q;
   assign drop_count      = drop_q;
   assign drp_timeout_err = err_q;
   // sequencing: voltage read, then current read, then one publish cycle; eos while busy is remembered once
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      rd_addr   = VOLTAGE_DRP_ADDR;
      v_hold_d  = v_hold_q;
      c_hold_d  = c_hold_q;
      pending_d = (state_q == IDLE) ? 1'b0 : (pending_q | eos);
      case (state_q)
         IDLE: begin
            start   = eos | pending_q;
            state_d = (eos | pending_q) ? V_WAIT : IDLE;
         end
         V_WAIT: begin
            start    = rd_done;
            rd_addr  = CURRENT_DRP_ADDR;
            v_hold_d = rd_done ? rd_data : v_hold_q;
            state_d  = rd_done ? C_WAIT : (rd_timeout ? IDLE : V_WAIT);
         end
         C_WAIT: begin
            c_hold_d = rd_done ? rd_data : c_hold_q;
            state_d  = rd_done ? PUBLISH : (rd_timeout ? IDLE : C_WAIT);
         end
         default: state_d = IDLE;
      endcase
   end
   // a pair is loaded only when both slots are free, keeping the two streams sample-aligned
   always_comb begin
      load      = (state_q == PUBLISH) & (~v_valid_q | voltage_tready) & (~c_valid_q | current_tready);
      drop      = (state_q == PUBLISH) & ~load;
      v_valid_d = load | (v_valid_q & ~voltage_tready);
      c_valid_d = load | (c_valid_q & ~current_tready);
      v_data_d  = load ? {SAMPLE_HEADER, v_hold_q} : v_data_q;
      c_data_d  = load ? {SAMPLE_HEADER, c_hold_q} : c_data_q;
      drop_d    = (drop & ~&drop_q) ? drop_q + 1'b1 : drop_q;
      err_d     = err_q | rd_timeout;
   end
   // sampler state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         v_hold_q  <= '0;
         c_hold_q  <= '0;
         v_data_q  <= '0;
         c_data_q  <= '0;
         v_valid_q <= 1'b0;
         c_valid_q <= 1'b0;
         drop_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         v_hold_q  <= v_hold_d;
         c_hold_q  <= c_hold_d;
         v_data_q  <= v_data_d;
         c_data_q  <= c_data_d;
         v_valid_q <= v_valid_d;
         c_valid_q <= c_valid_d;
         drop_q    <= drop_d;
         err_q     <= err_d;
      end
   end
endmodule
